x9dn_stim_tx: RTL and testbench

X9DN_STIM_TX -- requirements
Module: x9dn_stim_tx

---
 rtl/x9dn_stim_tx.sv | 121 ++++++++++++
 tb/tb_x9dn_stim_tx.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/x9dn_stim_tx.sv
// rtl/x9dn_stim_tx.sv - serial transmitter for 27-bit stimulus vectors (start, x0..x26 LSB first, stop)
// Optional even-parity bit between data and stop: define X9DN_TX_PARITY_EN.
module x9dn_stim_tx #(
   parameter int DIV_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [DIV_W-1:0] div,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [26:0]      in_data,
   output logic             tx,
   output logic             busy,
   output logic             done
);

`ifdef X9DN_TX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

   state_t           r_state;
   state_t           w_next;
   logic [DIV_W-1:0] r_cnt;
   logic [DIV_W-1:0] r_div;
   logic [26:0]      r_shift;
   logic [4:0]       r_bit;
   logic             r_done;
`ifdef X9DN_TX_PARITY_EN
   logic             r_par;
`endif
   logic             w_tick;
   logic             w_accept;
   logic             w_tx;

   assign w_tick   = (r_cnt == '0);
   assign w_accept = in_valid && (r_state == IDLE);
   assign in_ready = (r_state == IDLE);
   assign busy     = (r_state != IDLE);
   assign done     = r_done;
   assign tx       = w_tx;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      w_tx   = 1'b1;
      case (r_state)
         IDLE: begin
            if (w_accept) w_next = START;
         end
         START: begin
            w_tx = 1'b0;
            if (w_tick) w_next = DATA;
         end
         DATA: begin
            w_tx = r_shift[0];
            if (w_tick && (r_bit == 5'd26)) begin
`ifdef X9DN_TX_PARITY_EN
               w_next = PARITY;
`else
               w_next = STOP;
`endif
            end
         end
`ifdef X9DN_TX_PARITY_EN
         PARITY: begin
            w_tx = r_par;
            if (w_tick) w_next = STOP;
         end
`endif
         STOP: begin
            if (w_tick) w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   // Bit timing: r_cnt counts down from the latched divisor; zero marks the last clock of a bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt   <= '0;
         r_div   <= '0;
         r_shift <= '0;
         r_bit   <= '0;
         r_done  <= 1'b0;
`ifdef X9DN_TX_PARITY_EN
         r_par   <= 1'b0;
`endif
      end else begin
         r_done <= (r_state == STOP) && w_tick;
         if (w_accept) begin
            r_div   <= div;
            r_cnt   <= div;
            r_shift <= in_data;
            r_bit   <= '0;
`ifdef X9DN_TX_PARITY_EN
            r_par   <= ^in_data;
`endif
         end else if (r_state != IDLE) begin
            if (w_tick) begin
               r_cnt <= r_div;
               if (r_state == DATA) begin
                  r_shift <= r_shift >> 1;
                  r_bit   <= r_bit + 5'd1;
               end
            end else begin
               r_cnt <= r_cnt - DIV_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_x9dn_stim_tx.sv
// tb/tb_x9dn_stim_tx.sv - self-checking bench for x9dn_stim_tx against a bit-sequence reference model
module tb_x9dn_stim_tx;

`ifdef X9DN_TX_PARITY_EN
   localparam int P = 1;
`else
   localparam int P = 0;
`endif

   logic        clk;
   logic        rst_n;
   logic [7:0]  div;
   logic        in_valid;
   logic        in_ready;
   logic [26:0] in_data;
   logic        tx;
   logic        busy;
   logic        done;

   int n_assert = 0;
   int n_fail   = 0;

   x9dn_stim_tx #(.DIV_W(8)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .div      (div),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .tx       (tx),
      .busy     (busy),
      .done     (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle(input string tag, input logic exp_done);
      chk({tag, " tx"},       32'(tx),       32'd1);
      chk({tag, " busy"},     32'(busy),     32'd0);
      chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
      chk({tag, " done"},     32'(done),     32'(exp_done));
   endtask

   // Call at a negedge with the word already offered; returns at the negedge of the done cycle.
   task automatic run_frame(input logic [26:0] d, input int dv, input bit hold,
                            input logic [26:0] nd, input int ndv, input string tag);
      logic exp_q[$];
      logic lvl;
      exp_q = {};
      for (int b = 0; b < 29 + P; b++) begin
         if (b == 0)            lvl = 1'b0;
         else if (b <= 27)      lvl = d[b-1];
         else if (P == 1 && b == 28) lvl = ^d;
         else                   lvl = 1'b1;
         for (int r = 0; r <= dv; r++) exp_q.push_back(lvl);
      end
      @(negedge clk);
      if (hold) begin
         in_data = nd;
         div     = 8'(ndv);
      end else begin
         in_valid = 1'b0;
         in_data  = 27'($urandom);
         div      = 8'($urandom_range(0, 7));
      end
      chk({tag, " frame length"}, 32'(exp_q.size()), 32'((29 + P) * (dv + 1)));
      for (int i = 0; i < exp_q.size(); i++) begin
         chk($sformatf("%s tx[%0d]", tag, i), 32'(tx), 32'(exp_q[i]));
         chk($sformatf("%s busy[%0d]", tag, i), 32'(busy), 32'd1);
         chk($sformatf("%s ready[%0d]", tag, i), 32'(in_ready), 32'd0);
         chk($sformatf("%s done[%0d]", tag, i), 32'(done), 32'd0);
         @(negedge clk);
      end
      chk_idle({tag, " end"}, 1'b1);
   endtask

   initial begin
      logic [26:0] d;
      logic [26:0] d2;
      int dv;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      div      = '0;
      @(negedge clk);
      @(negedge clk);
      chk_idle("reset", 1'b0);
      rst_n = 1'b1;
      @(negedge clk);
      chk_idle("post-reset", 1'b0);

      // Single one in x0, div=0
      in_valid = 1'b1; in_data = 27'h0000001; div = 8'd0;
      run_frame(27'h0000001, 0, 1'b0, '0, 0, "x0only");
      @(negedge clk);
      chk_idle("x0only after", 1'b0);

      // All ones, div=0 (parity bit 1 when compiled in)
      in_valid = 1'b1; in_data = 27'h7FFFFFF; div = 8'd0;
      run_frame(27'h7FFFFFF, 0, 1'b0, '0, 0, "ones");
      @(negedge clk);

      // Alternating pattern at div=3; inputs scrambled mid-frame must be ignored
      in_valid = 1'b1; in_data = 27'h5555555; div = 8'd3;
      run_frame(27'h5555555, 3, 1'b0, '0, 0, "alt_div3");
      @(negedge clk);

      // in_valid held high: second word accepted on the done cycle, div 3 -> 0 between frames
      d  = 27'($urandom);
      d2 = 27'($urandom);
      in_valid = 1'b1; in_data = d; div = 8'd3;
      run_frame(d, 3, 1'b1, d2, 0, "chain_a");
      run_frame(d2, 0, 1'b0, '0, 0, "chain_b");
      @(negedge clk);
      chk_idle("chain gap", 1'b0);

      // Reset during DATA bit 10 at div=1
      d = 27'h0000400 | 27'($urandom);
      in_valid = 1'b1; in_data = d; div = 8'd1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (22) @(negedge clk);
      chk("pre-abort bit10", 32'(tx), 32'(d[10]));
      chk("pre-abort busy", 32'(busy), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk_idle("async reset", 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         chk_idle($sformatf("after abort %0d", i), 1'b0);
      end

      // Randomized frames
      for (int k = 0; k < 8; k++) begin
         d  = 27'($urandom);
         dv = $urandom_range(0, 5);
         in_valid = 1'b1; in_data = d; div = 8'(dv);
         run_frame(d, dv, 1'b0, '0, 0, $sformatf("rand%0d", k));
         if ($urandom_range(0, 1) == 1) begin
            @(negedge clk);
            chk_idle($sformatf("rand%0d idle", k), 1'b0);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
